pb_word_to_bcd: RTL

Sequential capture-and-convert stage between the PicoBlaze output bus and the seven-segment display driver. Assembles a 16-bit binary word from two byte writes on the `port_id`/`out_port`/`write_strobe` bus, then converts it to 5-digit packed BCD with a one-bit-per-clock double-dabble engine. The lower four digits feed the 4-digit display as `packed_hex`; the full captured word drives the LEDs.

---
 rtl/pb_word_to_bcd.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pb_word_to_bcd.sv
// Captures a 16-bit word from two PicoBlaze port writes and converts it to 5-digit packed BCD.
// Optional macro BCD_8BIT_COMPAT_EN: a LO_PORT write also commits {8'h00, data}.
module pb_word_to_bcd #(
  parameter logic [7:0] LO_PORT = 8'h01,
  parameter logic [7:0] HI_PORT = 8'h02
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  port_id,
  input  logic        write_strobe,
  input  logic [7:0]  out_port,
  output logic [15:0] value,
  output logic [19:0] bcd,
  output logic [15:0] packed_hex,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e      state_q, state_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] value_q, value_d;
  logic [15:0] shift_q, shift_d;
  logic [19:0] acc_q, acc_d;
  logic [19:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic        lo_wr, hi_wr, commit;
  logic [15:0] commit_word;
  logic [19:0] acc_adj;
  logic [35:0] shifted;

  assign lo_wr = write_strobe && (port_id == LO_PORT);
  assign hi_wr = write_strobe && (port_id == HI_PORT);

`ifdef BCD_8BIT_COMPAT_EN
  assign commit      = hi_wr || lo_wr;
  assign commit_word = hi_wr ? {out_port, lo_q} : {8'h00, out_port};
`else
  assign commit      = hi_wr;
  assign commit_word = {out_port, lo_q};
`endif

  // Add-3 correction on every digit before the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {acc_adj, shift_q} << 1;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    value_d = value_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (lo_wr) begin
      lo_d = out_port;
    end

    unique case (state_q)
      StIdle: ;
      StConv: begin
        acc_d   = shifted[35:16];
        shift_d = shifted[15:0];
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          bcd_d   = shifted[35:16];
          ovf_d   = (shifted[35:32] != 4'd0);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A commit restarts the engine; a result finishing on the same edge still lands.
    if (commit) begin
      value_d = commit_word;
      shift_d = commit_word;
      acc_d   = 20'd0;
      cnt_d   = 5'd0;
      state_d = StConv;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lo_q    <= 8'd0;
      value_q <= 16'd0;
      shift_q <= 16'd0;
      acc_q   <= 20'd0;
      bcd_q   <= 20'd0;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      value_q <= value_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign value      = value_q;
  assign bcd        = bcd_q;
  assign packed_hex = bcd_q[15:0];
  assign ovf        = ovf_q;
  assign busy       = (state_q == StConv);
  assign done       = done_q;

endmodule
